// File: rtl/commit_unit_pkg.sv
// Shared types for the commit unit: FSM states, RISC-V opcode constants, ROB entry/status structs.
// Optional build macro: COMMIT_PERF_EN (adds retire/mispredict performance counters to commit_unit).
package commit_unit_pkg;

  localparam int DEF_NUM_ROB_ENTRY = 16;
  localparam int DEF_ROB_WIDTH     = 4;
  localparam int DEF_PHY_WIDTH     = 6;
  localparam int DEF_ARCH_REGS     = 32;
  localparam int DEF_SQ_WIDTH      = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RESTORE = 2'd2
  } commit_state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic                         valid;
    logic [6:0]                   opcode;
    logic [4:0]                   rd_arch;
    logic [DEF_PHY_WIDTH-1:0]     rd_phy_old;
    logic [DEF_PHY_WIDTH-1:0]     rd_phy_new;
    logic [DEF_SQ_WIDTH-1:0]      store_id;
    logic                         mispredict;
    logic [31:0]                  update_pc;
    logic [31:0]                  actual_target;
    logic                         actual_taken;
  } rob_entry_t;

  typedef struct packed {
    rob_entry_t [DEF_NUM_ROB_ENTRY-1:0] entry;
    logic [DEF_NUM_ROB_ENTRY-1:0]       rob_finish;
    logic [DEF_ROB_WIDTH-1:0]           rob_head;
    logic                               rob_empty;
  } ROB_status_t;

  function automatic logic writes_rd(input logic [6:0] op);
    return !(op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH || op == OP_JAL || op == OP_JALR);
  endfunction

endpackage

// File: rtl/commit_unit_rrat.sv
// Retirement RAT: ARCH_REGS x PHY_WIDTH register file, one write port, whole array visible.
// Resets to the identity mapping (arch reg i -> phys tag i).
module commit_rrat #(
  parameter int ARCH_REGS = 32,
  parameter int PHY_WIDTH = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                we,
  input  logic [4:0]                          waddr,
  input  logic [PHY_WIDTH-1:0]                wdata,
  output logic [ARCH_REGS-1:0][PHY_WIDTH-1:0] table_out
);

  logic [ARCH_REGS-1:0][PHY_WIDTH-1:0] rrat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rrat_q[i] <= PHY_WIDTH'(i);
      end
    end else if (we) begin
      rrat_q[waddr] <= wdata;
    end
  end

  assign table_out = rrat_q;

endmodule

// File: rtl/commit_unit.sv
// In-order commit stage: retires the ROB head, trains the predictor, and runs flush/restore on mispredicts.
// Optional build macro: COMMIT_PERF_EN adds perf_commit_cnt / perf_mispredict_cnt outputs.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int NUM_ROB_ENTRY = DEF_NUM_ROB_ENTRY,
  parameter int ROB_WIDTH     = DEF_ROB_WIDTH,
  parameter int PHY_WIDTH     = DEF_PHY_WIDTH,
  parameter int ARCH_REGS     = DEF_ARCH_REGS,
  parameter int SQ_WIDTH      = DEF_SQ_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  ROB_status_t                         rob_status,
  output logic                                commit_valid,
  output logic [4:0]                          commit_rd_arch,
  output logic [PHY_WIDTH-1:0]                commit_rd_phy,
  output logic                                free_valid,
  output logic [PHY_WIDTH-1:0]                free_phy,
  output logic                                store_commit_valid,
  output logic [SQ_WIDTH-1:0]                 store_commit_id,
  output logic                                bp_update_valid,
  output logic [31:0]                         bp_update_pc,
  output logic [31:0]                         bp_update_target,
  output logic                                bp_update_taken,
  output logic                                flush,
  output logic                                redirect_valid,
  output logic [31:0]                         redirect_pc,
  output logic                                rrat_restore_valid,
  output logic [ARCH_REGS-1:0][PHY_WIDTH-1:0] rrat_restore
`ifdef COMMIT_PERF_EN
  ,
  output logic [31:0]                         perf_commit_cnt,
  output logic [31:0]                         perf_mispredict_cnt
`endif
);

  commit_state_t            state;
  logic [ROB_WIDTH-1:0]     head;
  logic [NUM_ROB_ENTRY-1:0] finish;
  rob_entry_t               head_e;
  logic                     retire;
  logic                     rrat_we;

  assign head   = rob_status.rob_head;
  assign finish = rob_status.rob_finish;
  assign head_e = rob_status.entry[head];

  // Only RUN retires; heads seen during FLUSH/RESTORE belong to the squashed path.
  assign retire  = (state == RUN) && !rob_status.rob_empty && finish[head] && head_e.valid;
  assign rrat_we = retire && writes_rd(head_e.opcode) && (head_e.rd_arch != 5'd0);

  commit_rrat #(
    .ARCH_REGS (ARCH_REGS),
    .PHY_WIDTH (PHY_WIDTH)
  ) u_rrat (
    .clk       (clk),
    .rst       (rst),
    .we        (rrat_we),
    .waddr     (head_e.rd_arch),
    .wdata     (head_e.rd_phy_new),
    .table_out (rrat_restore)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= RUN;
      commit_valid       <= 1'b0;
      commit_rd_arch     <= '0;
      commit_rd_phy      <= '0;
      free_valid         <= 1'b0;
      free_phy           <= '0;
      store_commit_valid <= 1'b0;
      store_commit_id    <= '0;
      bp_update_valid    <= 1'b0;
      bp_update_pc       <= '0;
      bp_update_target   <= '0;
      bp_update_taken    <= 1'b0;
      flush              <= 1'b0;
      redirect_valid     <= 1'b0;
      redirect_pc        <= '0;
      rrat_restore_valid <= 1'b0;
    end else begin
      commit_valid       <= 1'b0;
      free_valid         <= 1'b0;
      store_commit_valid <= 1'b0;
      bp_update_valid    <= 1'b0;
      flush              <= 1'b0;
      redirect_valid     <= 1'b0;
      rrat_restore_valid <= 1'b0;
      case (state)
        RUN: begin
          if (retire) begin
            commit_valid   <= 1'b1;
            commit_rd_arch <= head_e.rd_arch;
            commit_rd_phy  <= head_e.rd_phy_new;
            if (rrat_we) begin
              free_valid <= 1'b1;
              free_phy   <= head_e.rd_phy_old;
            end
            if (head_e.opcode == OP_STORE) begin
              store_commit_valid <= 1'b1;
              store_commit_id    <= head_e.store_id;
            end
            if (is_ctrl(head_e.opcode)) begin
              bp_update_valid  <= 1'b1;
              bp_update_pc     <= head_e.update_pc;
              bp_update_target <= head_e.actual_target;
              bp_update_taken  <= head_e.actual_taken;
            end
            // flush is raised with the retire so it is high exactly while state==FLUSH
            if (head_e.mispredict) begin
              flush          <= 1'b1;
              redirect_valid <= 1'b1;
              redirect_pc    <= head_e.actual_taken ? head_e.actual_target
                                                    : head_e.update_pc + 32'd4;
              state          <= FLUSH;
            end
          end
        end
        FLUSH: begin
          rrat_restore_valid <= 1'b1;
          state              <= RESTORE;
        end
        RESTORE: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef COMMIT_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_commit_cnt     <= '0;
      perf_mispredict_cnt <= '0;
    end else begin
      if (commit_valid) perf_commit_cnt <= perf_commit_cnt + 32'd1;
      if (flush)        perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
    end
  end
`endif

endmodule
